// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file and its busy scoreboard.
//   - Default register width and address width.
//   - Index of the hard-wired zero register.
//   - port_slice(): returns field 'idx' of a packed vector of equal-width fields.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // Register that reads as zero when the zero-register option is enabled
  localparam int unsigned ZERO_IDX = 0;

  // Upper bounds of the generic slice helper.
  // Callers cast their vector up to SLICE_VEC_W and cast the result down to the field width.
  localparam int unsigned SLICE_VEC_W = 512;
  localparam int unsigned SLICE_MAX_W = 128;

  // Field 'idx' (width 'width') of a packed vector whose field 0 is in the LSBs
  function automatic logic [SLICE_MAX_W-1:0] port_slice(
    input logic [SLICE_VEC_W-1:0] vec,
    input int unsigned            idx,
    input int unsigned            width
  );
    return SLICE_MAX_W'(vec >> (idx * width));
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Per-register busy scoreboard for multi-cycle producers.
// A register is marked busy when its producer issues.
// It is released when either write port returns a result for it.
// Ports:
//   clk, rst                  clock, synchronous active-high reset (clears every bit)
//   set_i / set_idx_i         reserve a register (issue of a multi-cycle op)
//   clr_a_i / clr_a_idx_i     write port A completing a register
//   clr_b_i / clr_b_idx_i     write port B completing a register
//   busy_o                    registered busy vector, one bit per register
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_a_i,
  input  logic [ADDR_W-1:0] clr_a_idx_i,
  input  logic              clr_b_i,
  input  logic [ADDR_W-1:0] clr_b_idx_i,
  output logic [DEPTH-1:0]  busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Next busy vector: clears are applied first so that a same-cycle reserve
  // (a newer producer) overrides the completion of the older one.
  always_comb begin
    busy_d = busy_q;
    if (clr_a_i) busy_d[clr_a_idx_i] = 1'b0;
    if (clr_b_i) busy_d[clr_b_idx_i] = 1'b0;
    if (set_i)   busy_d[set_idx_i]   = 1'b1;
    if (ZERO_REG) busy_d[ADDR_W'(ZERO_IDX)] = 1'b0;
  end

  // Busy state register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the pipelined core.
// It has NRD combinational read ports and two write ports:
//   - A: ALU writeback. A wins when both ports write the same register.
//   - B: load / multi-cycle return.
// Options:
//   - Write-to-read bypass.
//   - Busy scoreboard for multi-cycle producers.
//   - Hard-wired zero register.
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   readreg  [NRD*ADDR_W]                  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   readdata [NRD*DATA_W]                  read data per port (combinational)
//   readbusy [NRD]                         busy flag of each addressed register
//   RegWrite / writereg / writedata        write port A
//   RegWrite2 / writereg2 / writedata2     write port B
//   reserve / reservereg                   mark a register busy
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NRD      = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] readreg,
  output logic [NRD*DATA_W-1:0] readdata,
  output logic [NRD-1:0]        readbusy,
  input  logic                  RegWrite,
  input  logic [ADDR_W-1:0]     writereg,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  RegWrite2,
  input  logic [ADDR_W-1:0]     writereg2,
  input  logic [DATA_W-1:0]     writedata2,
  input  logic                  reserve,
  input  logic [ADDR_W-1:0]     reservereg
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic we_a;
  logic we_b;
  logic rsv_en;

  // Effective enables: anything aimed at the zero register is dropped here,
  // so storage, bypass and scoreboard all see the same filtered request.
  assign we_a   = RegWrite  & ~(ZERO_REG & (writereg   == ADDR_W'(ZERO_IDX)));
  assign we_b   = RegWrite2 & ~(ZERO_REG & (writereg2  == ADDR_W'(ZERO_IDX)));
  assign rsv_en = reserve   & ~(ZERO_REG & (reservereg == ADDR_W'(ZERO_IDX)));

  // Next storage contents; port A is applied last so it wins an address collision
  always_comb begin
    regs_d = regs_q;
    if (we_b) regs_d[writereg2] = writedata2;
    if (we_a) regs_d[writereg]  = writedata;
  end

  // Storage register
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_sb #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_i       (rsv_en),
    .set_idx_i   (reservereg),
    .clr_a_i     (we_a),
    .clr_a_idx_i (writereg),
    .clr_b_i     (we_b),
    .clr_b_idx_i (writereg2),
    .busy_o      (busy)
  );

  // Independent read ports.
  // The bypass only selects among the write inputs and stored values,
  // so readdata never feeds back into the write path.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic              hit_a;
    logic              hit_b;
    logic              hit_rsv;
    logic              is_zero;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;

    assign raddr   = ADDR_W'(port_slice(SLICE_VEC_W'(readreg), i, ADDR_W));
    assign hit_a   = we_a   & (writereg   == raddr);
    assign hit_b   = we_b   & (writereg2  == raddr);
    assign hit_rsv = rsv_en & (reservereg == raddr);
    assign is_zero = ZERO_REG & (raddr == ADDR_W'(ZERO_IDX));

    // Read mux.
    // A same-cycle write releases the busy flag early unless a new reserve re-claims the register.
    always_comb begin
      rdata = regs_q[raddr];
      rbusy = busy[raddr];
      if (BYPASS) begin
        if (hit_a) begin
          rdata = writedata;
        end else if (hit_b) begin
          rdata = writedata2;
        end
        if ((hit_a | hit_b) & ~hit_rsv) rbusy = 1'b0;
      end
      if (is_zero) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign readdata[i*DATA_W +: DATA_W] = rdata;
    assign readbusy[i]                  = rbusy;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, two-read 32x32 register file in the single-cycle datapath.
- Adds the following over that block:
  - N read ports.
  - Two write ports: ALU writeback and load/multi-cycle return.
  - Optional write-to-read bypass.
  - Per-register busy scoreboard for multi-cycle producers.
  - Synchronous clear.
- Sits between decode and writeback in the pipelined core.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a read returns this cycle's write data; 0 = a read returns the stored value.
- ZERO_REG, 1, 1 = register 0 reads 0, and writes/reserves to it are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- readreg  in  NRD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- readdata  out  NRD*DATA_W  read data per port (combinational).
- readbusy  out  NRD  busy flag of the addressed register, per port.
- RegWrite  in  1  write enable, port A (ALU writeback).
- writereg  in  ADDR_W  write address, port A.
- writedata  in  DATA_W  write data, port A.
- RegWrite2  in  1  write enable, port B (load/multi-cycle return).
- writereg2  in  ADDR_W  write address, port B.
- writedata2  in  DATA_W  write data, port B.
- reserve  in  1  mark reservereg busy (issue of a multi-cycle op).
- reservereg  in  ADDR_W  register to reserve.

Behaviour:
- Reset: rst sampled high at a rising edge clears all DEPTH registers to 0 and all busy bits to 0, in one cycle.
  - While rst is high, writes and reserves are ignored.
  - After reset, every readdata = 0 and every readbusy = 0.
  - Reset asserted mid-operation discards pending reservations.
- Write: on the rising edge, if an enable is high the addressed register takes the data. Write latency is 1 edge.
- Same-address collision: if both ports write the same address in one cycle, port A (RegWrite) wins and port B data is dropped.
- Different addresses: both writes commit in the same cycle.
- ZERO_REG=1:
  - Writes and reserves addressed to 0 have no effect.
  - readdata for address 0 = 0 and readbusy = 0, bypass included.
- Read, BYPASS=0: readdata[i] = stored value of readreg[i], purely combinational.
- Read, BYPASS=1: if readreg[i] matches an enabled write address this cycle, readdata[i] = that write's data, using port A > port B priority; otherwise the stored value.
  - The bypass path must not create a combinational path from readdata back to write inputs inside the block.
- Scoreboard:
  - busy[r] is set at the edge where reserve=1 and reservereg=r.
  - busy[r] is cleared at the edge where either write port writes r.
  - Reserve and write to the same r in one cycle: reserve wins, so busy stays 1 (a new producer supersedes the completing one). The data write still commits.
  - Reserving an already-busy register: it stays busy, no error.
- readbusy[i] reflects the registered busy bit of readreg[i].
  - With BYPASS=1 it is forced to 0 when a write to that address occurs in the same cycle and no reserve targets it in that cycle.
  - With BYPASS=0 there is no forcing.
- All addresses are in range by construction; there is no out-of-range handling.
- Read ports are independent: any number may address the same register.

Decomposition:
- Shared package regfile_pkg:
  - Defaults for DATA_W and ADDR_W.
  - Function to extract port slices from packed vectors.
  - Constant for the zero-register index.
- One natural sub-module, regfile_sb: the busy-bit scoreboard.
  - Inputs: set, clear A, clear B, rst.
  - Output: busy vector.
  - Keeps storage and hazard tracking separable for reuse in the decode stage.
- Storage, write priority and bypass muxing stay in regfile_mp.

Test Plan:
- Reset then read: preload r5=0xDEAD via a write, assert rst one cycle → all ports read 0 and readbusy=0 for r0..r31.
- Write/read, BYPASS=0: write r1=10 → readdata for r1 is still the old value (0) in the same cycle and 10 after the edge; write r0=77 with ZERO_REG=1 → r0 reads 0.
- Collision: RegWrite r7=0x11 and RegWrite2 r7=0x22 in the same cycle → r7=0x11 after the edge. Separate addresses r8=0x33 and r9=0x44 → both committed.
- Bypass, BYPASS=1, NRD=3: all ports read r4 while RegWrite r4=0x55 is active → all three readdata = 0x55 in that cycle.
- Scoreboard:
  - reserve r3 → readbusy=1 from the next cycle.
  - RegWrite2 r3=0x99 → busy clears after that edge, and readbusy=0 in the write cycle when BYPASS=1.
  - reserve r3 together with a write to r3 → busy stays 1 and data = the written value.
- Reset mid-operation: reserve r10, r11, then rst coinciding with RegWrite r10=5 → r10 reads 0 and both busy flags are 0 after the edge.
